// File: rtl/ahbl_sram_wbuf.sv
// ahbl_sram_wbuf: AHB-Lite SRAM slave with a one-entry posted write
// buffer, read forwarding, byte lanes, error decode and read wait states.
module ahbl_sram_wbuf #(
    parameter int AHB_DWIDTH = 32,
    parameter int AHB_AWIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_WAIT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HREADYIN,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic [AHB_AWIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [AHB_DWIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [AHB_DWIDTH-1:0] HRDATA,
    output logic                  BUSY
);

    localparam int NB    = AHB_DWIDTH / 8;
    localparam int BL    = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int WA_W  = AHB_AWIDTH - BL;
    localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_RWAIT,
        S_RDATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state_q, state_d, beat_d;

    logic [WA_W-1:0]       waddr;
    logic [BL-1:0]         lane;
    logic [BL-1:0]         amask;
    logic [IDX_W-1:0]      idx;
    logic [NB-1:0]         bmask;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  dec_err;

    logic                  can_acc;
    logic                  acc;
    logic                  rd_issue;
    logic                  wr_direct;

    logic [IDX_W-1:0]      a_idx_q;
    logic [NB-1:0]         a_mask_q;

    logic                  buf_v_q;
    logic [IDX_W-1:0]      buf_idx_q;
    logic [NB-1:0]         buf_mask_q;
    logic [AHB_DWIDTH-1:0] buf_data_q;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [NB-1:0]         mem_wmask;
    logic [AHB_DWIDTH-1:0] mem_wdata;
    logic [AHB_DWIDTH-1:0] mem_q;
    logic [AHB_DWIDTH-1:0] merged;
    logic [AHB_DWIDTH-1:0] rd_hold_q;

    logic                  rd_first_q;
    logic [1:0]            wcnt_q;

    logic                  unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

    // address-phase decode: word index, lane mask and error checks
    always_comb begin
        waddr     = HADDR[AHB_AWIDTH-1:BL];
        lane      = HADDR[BL-1:0];
        idx       = HADDR[BL+IDX_W-1:BL];
        range_err = waddr >= WA_W'(MEM_DEPTH);
        size_err  = HSIZE > 3'(BL);
        amask     = '0;
        for (int i = 0; i < BL; i++) begin
            amask[i] = (i < int'(HSIZE));
        end
        align_err = (lane & amask) != '0;
        bmask     = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[b] = (b >= int'(lane)) &&
                       (b < int'(lane) + (1 << HSIZE));
        end
        dec_err = range_err | size_err | align_err;
    end

    // beat acceptance and memory port arbitration
    always_comb begin
        can_acc = (state_q == S_IDLE)  || (state_q == S_WDATA) ||
                  (state_q == S_RDATA) || (state_q == S_ERR2);
        acc       = can_acc & HSEL & HREADYIN & HTRANS[1];
        rd_issue  = acc & ~dec_err & ~HWRITE;
        wr_direct = (state_q == S_WDATA) & ~rd_issue;
        mem_we    = 1'b0;
        mem_widx  = a_idx_q;
        mem_wmask = a_mask_q;
        mem_wdata = HWDATA;
        if (wr_direct) begin
            mem_we = ~HRESET;
        end else if (buf_v_q && !rd_issue) begin
            mem_we    = ~HRESET;
            mem_widx  = buf_idx_q;
            mem_wmask = buf_mask_q;
            mem_wdata = buf_data_q;
        end
    end

    // byte-lane single-port banks; a read issue owns the port
    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] ram [MEM_DEPTH];
        logic [7:0] rq;
        // one access per lane per cycle: read or masked write
        always_ff @(posedge HCLK) begin
            if (rd_issue) begin
                rq <= ram[idx];
            end else if (mem_we && mem_wmask[b]) begin
                ram[mem_widx] <= mem_wdata[b*8 +: 8];
            end
        end
        assign mem_q[b*8 +: 8] = rq;
    end

    // latch index and lane mask of each accepted good beat
    always_ff @(posedge HCLK) begin
        if (acc && !dec_err) begin
            a_idx_q  <= idx;
            a_mask_q <= bmask;
        end
    end

    // posted write buffer: fill on write/read collision, drain when idle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            buf_v_q <= 1'b0;
        end else if (state_q == S_WDATA && rd_issue) begin
            buf_v_q    <= 1'b1;
            buf_idx_q  <= a_idx_q;
            buf_mask_q <= a_mask_q;
            buf_data_q <= HWDATA;
        end else if (!rd_issue && !wr_direct) begin
            buf_v_q <= 1'b0;
        end
    end

    // forward buffered bytes over stale memory read data
    always_comb begin
        merged = mem_q;
        for (int b = 0; b < NB; b++) begin
            if (buf_v_q && buf_idx_q == a_idx_q && buf_mask_q[b]) begin
                merged[b*8 +: 8] = buf_data_q[b*8 +: 8];
            end
        end
    end

    // hold the merged word for reads that stall in RWAIT
    always_ff @(posedge HCLK) begin
        if (rd_first_q) begin
            rd_hold_q <= merged;
        end
    end

    // state register, first-data-cycle flag and wait counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            rd_first_q <= 1'b0;
            wcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_first_q <= rd_issue;
            wcnt_q     <= (state_q == S_RWAIT) ? wcnt_q + 2'd1 : 2'd0;
        end
    end

    // next state: sticky error/wait states, else follow the new beat
    always_comb begin
        beat_d = S_IDLE;
        unique case (1'b1)
            !acc:                      beat_d = S_IDLE;
            acc && dec_err:            beat_d = S_ERR1;
            acc && !dec_err && HWRITE: beat_d = S_WDATA;
            acc && !dec_err && !HWRITE:
                beat_d = (RD_WAIT > 0) ? S_RWAIT : S_RDATA;
        endcase
        case (state_q)
            S_ERR1:  state_d = S_ERR2;
            S_RWAIT: state_d = (wcnt_q == WAIT_LAST) ? S_RDATA : S_RWAIT;
            default: state_d = beat_d;
        endcase
    end

    // bus outputs decoded from the current state
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = '0;
        BUSY      = (state_q != S_IDLE) | buf_v_q;
        case (state_q)
            S_RWAIT: HREADYOUT = 1'b0;
            S_RDATA: HRDATA = (RD_WAIT == 0) ? merged : rd_hold_q;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            S_ERR2:  HRESP = 2'b01;
            default: HREADYOUT = 1'b1;
        endcase
    end

endmodule
